top_accel: RTL and testbench
============================

TOP_ACCEL -- requirements
Module: top_accel

Interface
REQ-001 SHALL have parameter DATA_W, default 16, input element width (two's-complement signed).
REQ-002 SHALL have parameter ACC_W, default 32, result element width; ACC_W >= 2*DATA_W.
REQ-003 SHALL have parameter N, default 4, vector length; the result matrix is N x N.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous and active-high (asserted when 1).
REQ-006 SHALL have port start, input, 1, begin-job request sampled on the clk rising edge.
REQ-007 SHALL have port done, output, 1, job complete flag.
REQ-008 SHALL have port busy, output, 1, job in progress.
REQ-009 SHALL have ports s_axis_tvalid (in, 1), s_axis_tdata (in, DATA_W) and s_axis_tready (out, 1), the AXI-Stream input.
REQ-010 SHALL have ports m_axis_tvalid (out, 1), m_axis_tdata (out, ACC_W), m_axis_tlast (out, 1) and m_axis_tready (in, 1), the AXI-Stream output.

Function
REQ-011 SHALL compute the outer product C[i][j] = A[i]*B[j], i,j in 0..N-1: A is an N-element column vector, B an N-element row vector.
REQ-012 SHALL multiply signed: sign-extend each 2*DATA_W product to ACC_W.
REQ-013 SHALL use FSM states IDLE, LOAD_A, LOAD_B, COMPUTE, OUTPUT, DONE.
REQ-014 IDLE or DONE with start=1 at an edge SHALL go to LOAD_A, clear done and clear element counters.
REQ-015 start SHALL be ignored in LOAD_A, LOAD_B, COMPUTE and OUTPUT.
REQ-016 s_axis_tready SHALL be 1 exactly in LOAD_A and LOAD_B, decoded combinationally from state.
REQ-017 A beat SHALL be accepted only on an edge with s_axis_tvalid=1 and s_axis_tready=1; idle valid-low cycles do not advance the counters.
REQ-018 LOAD_A SHALL store beats in order A[0]..A[N-1]; after the Nth beat the FSM SHALL go to LOAD_B.
REQ-019 LOAD_B SHALL store beats B[0]..B[N-1]; after the Nth beat the FSM SHALL go to COMPUTE.
REQ-020 COMPUTE SHALL write one C element per cycle in row-major order (index k = i*N+j), taking N*N cycles, then go to OUTPUT.
REQ-021 OUTPUT SHALL drive m_axis_tvalid=1 with m_axis_tdata = C[k], k starting at 0.
REQ-022 k SHALL advance only on an edge with m_axis_tvalid=1 and m_axis_tready=1; data SHALL be held stable while tready=0.
REQ-023 m_axis_tlast SHALL be 1 only while k = N*N-1 and m_axis_tvalid=1.
REQ-024 After the handshake at k = N*N-1 the FSM SHALL go to DONE; m_axis_tvalid SHALL be 0 from the next cycle.
REQ-025 done SHALL be 1 exactly in DONE and SHALL remain 1 until a start is accepted or reset occurs.
REQ-026 busy SHALL be 1 in LOAD_A, LOAD_B, COMPUTE and OUTPUT, and 0 in IDLE and DONE.
REQ-027 m_axis_tvalid and m_axis_tlast SHALL be 0 outside OUTPUT; m_axis_tdata SHALL be 0 outside OUTPUT.
REQ-028 Input data presented while s_axis_tready=0 SHALL be ignored.

Reset
REQ-029 rst_n=1 SHALL immediately, independent of clk, force state IDLE and clear counters and the A, B and C buffers.
REQ-030 During reset done, busy, s_axis_tready, m_axis_tvalid, m_axis_tlast and m_axis_tdata SHALL all be 0.
REQ-031 Reset asserted mid-job SHALL abort the job; no further output beats until a new start after reset release.

Verification
REQ-032 Basic: start, then A=1,2,3,4, B=5,6,7,8, tready=1 -> C = 5,6,7,8,10,12,14,16,15,18,21,24,20,24,28,32; tlast only on the 16th beat; done=1 next cycle; busy=0.
REQ-033 Backpressure: same data, m_axis_tready toggling 1/0 -> identical 16 values in order; tdata stable while stalled.
REQ-034 Input gaps: s_axis_tvalid low for 3 cycles between beats -> identical result; no extra or lost beats.
REQ-035 Signed: A[0]=16'hFFFF (-1), B[0]=5, other inputs 0 -> C[0]=32'hFFFFFFFB; all other C values 0.
REQ-036 Start during busy: start pulsed during LOAD_B -> ignored; result same as REQ-032.
REQ-037 Reset mid-OUTPUT after 5 beats -> all outputs 0 at once; a new start then delivers a full 16-beat job.

Source files
------------

// File: rtl/top_accel.sv
// Outer-product accelerator: streams in column vector A and row vector B,
// computes C = A * B (N x N, signed) and streams C out in row-major order.
module top_accel #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned N      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              done,
    output logic              busy,
    input  logic              s_axis_tvalid,
    input  logic [DATA_W-1:0] s_axis_tdata,
    output logic              s_axis_tready,
    output logic              m_axis_tvalid,
    output logic [ACC_W-1:0]  m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
);

    localparam int unsigned NN = N * N;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned KW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(N - 1);
    localparam logic [KW-1:0] LastK   = KW'(NN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StCompute,
        StOutput,
        StDone
    } state_e;

    state_e state_q;

    logic [IW-1:0] row_q;
    logic [IW-1:0] col_q;
    logic [KW-1:0] k_q;

    logic signed [DATA_W-1:0] a_buf [N];
    logic signed [DATA_W-1:0] b_buf [N];
    logic        [ACC_W-1:0]  c_buf [NN];

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    assign prod     = a_buf[row_q] * b_buf[col_q];
    assign prod_ext = ACC_W'(prod);

    // All outputs are pure decodes of registered state, so reset zeroes them at once.
    assign s_axis_tready = (state_q == StLoadA) || (state_q == StLoadB);
    assign busy          = (state_q == StLoadA) || (state_q == StLoadB) ||
                           (state_q == StCompute) || (state_q == StOutput);
    assign done          = (state_q == StDone);
    assign m_axis_tvalid = (state_q == StOutput);
    assign m_axis_tlast  = (state_q == StOutput) && (k_q == LastK);
    assign m_axis_tdata  = (state_q == StOutput) ? c_buf[k_q] : '0;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            for (int i = 0; i < int'(N); i++) begin
                a_buf[i] <= '0;
                b_buf[i] <= '0;
            end
            for (int i = 0; i < int'(NN); i++) begin
                c_buf[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StLoadA;
                        row_q   <= '0;
                        col_q   <= '0;
                        k_q     <= '0;
                    end
                end
                StLoadA: begin
                    if (s_axis_tvalid) begin
                        a_buf[row_q] <= s_axis_tdata;
                        if (row_q == LastIdx) begin
                            row_q   <= '0;
                            state_q <= StLoadB;
                        end else begin
                            row_q <= row_q + IW'(1);
                        end
                    end
                end
                StLoadB: begin
                    if (s_axis_tvalid) begin
                        b_buf[row_q] <= s_axis_tdata;
                        if (row_q == LastIdx) begin
                            row_q   <= '0;
                            col_q   <= '0;
                            k_q     <= '0;
                            state_q <= StCompute;
                        end else begin
                            row_q <= row_q + IW'(1);
                        end
                    end
                end
                StCompute: begin
                    c_buf[k_q] <= prod_ext;
                    if (col_q == LastIdx) begin
                        col_q <= '0;
                        row_q <= row_q + IW'(1);
                    end else begin
                        col_q <= col_q + IW'(1);
                    end
                    if (k_q == LastK) begin
                        k_q     <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        state_q <= StOutput;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                StOutput: begin
                    if (m_axis_tready) begin
                        if (k_q == LastK) begin
                            k_q     <= '0;
                            state_q <= StDone;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_top_accel.sv
// Directed and randomized checks of top_accel against an outer-product model
// computed with plain integer arithmetic.
module tb_top_accel;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int N      = 4;
    localparam int NN     = N * N;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              done;
    logic              busy;
    logic              s_axis_tvalid = 1'b0;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tready;
    logic              m_axis_tvalid;
    logic [ACC_W-1:0]  m_axis_tdata;
    logic              m_axis_tlast;
    logic              m_axis_tready = 1'b0;

    top_accel #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .done          (done),
        .busy          (busy),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] a_v [N];
    logic [DATA_W-1:0] b_v [N];
    logic [ACC_W-1:0]  exp_c [NN];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_expected();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint p;
                p = longint'($signed(a_v[i])) * longint'($signed(b_v[j]));
                exp_c[i*N+j] = ACC_W'(p);
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_sready"}, 64'(s_axis_tready), 64'd0);
        check({tag, "_mvalid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, "_mlast"}, 64'(m_axis_tlast), 64'd0);
        check({tag, "_mdata"}, 64'(m_axis_tdata), 64'd0);
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        #2;
        check("start_done_clr", 64'(done), 64'd0);
        check("start_busy", 64'(busy), 64'd1);
        check("start_sready", 64'(s_axis_tready), 64'd1);
        @(posedge clk); #1;
    endtask

    // gap < 0 selects a random 0..3 idle cycles before each beat.
    task automatic send_all(input int gap, input bit start_in_b);
        for (int b = 0; b < 2 * N; b++) begin
            int g;
            logic rdy;
            int guard;
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int c = 0; c < g; c++) begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = DATA_W'($urandom);
                @(posedge clk); #1;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = (b < N) ? a_v[b] : b_v[b-N];
            if (start_in_b && b == N + 1) start = 1'b1;
            guard = 0;
            @(negedge clk) rdy = s_axis_tready;
            while (!rdy && guard < 20) begin
                @(posedge clk); #1;
                @(negedge clk) rdy = s_axis_tready;
                guard++;
            end
            if (!rdy) check("s_ready_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 16'h5a5a;
        #2;
        check("after_load_sready", 64'(s_axis_tready), 64'd0);
        check("after_load_busy", 64'(busy), 64'd1);
    endtask

    // mode 0: tready=1, 1: toggling, 2: random. Returns at posedge+1 after last handshake.
    task automatic collect(input int mode, input int stop_after);
        int k;
        int cyc;
        logic have_held;
        logic [ACC_W-1:0] held;
        k = 0;
        cyc = 0;
        have_held = 1'b0;
        held = '0;
        while (k < stop_after && cyc < 500) begin
            case (mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = (cyc % 2 == 0);
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (m_axis_tvalid) begin
                if (have_held) check("stall_hold", 64'(m_axis_tdata), 64'(held));
                have_held = 1'b0;
                if (m_axis_tready) begin
                    check($sformatf("c%0d", k), 64'(m_axis_tdata), 64'(exp_c[k]));
                    check($sformatf("tlast%0d", k), 64'(m_axis_tlast), 64'(k == NN - 1));
                    k++;
                end else begin
                    held = m_axis_tdata;
                    have_held = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (k < stop_after) check("out_timeout", 64'(k), 64'(stop_after));
    endtask

    task automatic check_finished();
        m_axis_tready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("fin_done", 64'(done), 64'd1);
            check("fin_busy", 64'(busy), 64'd0);
            check("fin_mvalid", 64'(m_axis_tvalid), 64'd0);
            check("fin_mdata", 64'(m_axis_tdata), 64'd0);
        end
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
    endtask

    task automatic basic_vectors();
        for (int i = 0; i < N; i++) begin
            a_v[i] = DATA_W'(i + 1);
            b_v[i] = DATA_W'(i + 5);
        end
        build_expected();
    endtask

    initial begin
        #1 rst_n = 1'b1;
        #1 check_quiet("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;

        // Valid data offered in IDLE must be dropped.
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'h7777;
        repeat (2) @(posedge clk);
        #1 check_quiet("idle_ignore");
        s_axis_tvalid = 1'b0;

        basic_vectors();
        do_start();
        send_all(0, 1'b0);
        collect(0, NN);
        check_finished();

        do_start();
        send_all(0, 1'b0);
        collect(1, NN);
        check_finished();

        do_start();
        send_all(3, 1'b0);
        collect(0, NN);
        check_finished();

        for (int i = 0; i < N; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        a_v[0] = 16'hFFFF;
        b_v[0] = 16'd5;
        build_expected();
        do_start();
        send_all(0, 1'b0);
        collect(0, NN);
        check_finished();

        basic_vectors();
        do_start();
        send_all(0, 1'b1);
        collect(0, NN);
        check_finished();

        // Abort mid-output after five beats.
        do_start();
        send_all(0, 1'b0);
        collect(0, 5);
        #2 rst_n = 1'b1;
        #1 check_quiet("midreset");
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_reset_mvalid", 64'(m_axis_tvalid), 64'd0);
            check("post_reset_done", 64'(done), 64'd0);
        end
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        do_start();
        send_all(0, 1'b0);
        collect(0, NN);
        check_finished();

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                a_v[i] = DATA_W'($urandom);
                b_v[i] = DATA_W'($urandom);
            end
            build_expected();
            do_start();
            send_all(-1, 1'b0);
            collect(2, NN);
            check_finished();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
